fb_access_arbiter: RTL and testbench

//  Single-port frame-buffer access controller; issues at most one memory op per clk.

---
 rtl/fb_access_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_fb_access_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fb_access_arbiter.sv
// Single-port frame-buffer arbiter: a display read port and two pixel writers
// share one RAM, with at most one RAM operation issued per clock.
module fb_access_arbiter #(
    parameter int BITS_PIXEL = 8,
    parameter int NUM_PIXEL  = 19200,
    parameter int ADDR_W     = 15,
    parameter int STARVE_LIM = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_valid_i,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic                  rd_ready,
    output logic                  rd_valid_o,
    output logic [BITS_PIXEL-1:0] rd_data,
    input  logic                  wa_valid,
    input  logic [BITS_PIXEL-1:0] wa_pixel,
    input  logic                  wa_sof,
    output logic                  wa_ready,
    output logic                  wa_frame,
    input  logic                  wb_valid,
    input  logic [ADDR_W-1:0]     wb_addr,
    input  logic [BITS_PIXEL-1:0] wb_pixel,
    output logic                  wb_ready,
    output logic                  wb_err,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [BITS_PIXEL-1:0] mem_wdata,
    input  logic [BITS_PIXEL-1:0] mem_rdata
);
    localparam int CNT_W = $clog2(STARVE_LIM + 1);
    localparam logic [CNT_W-1:0]  LIM       = CNT_W'(STARVE_LIM);
    localparam logic [ADDR_W:0]   DEPTH     = (ADDR_W + 1)'(NUM_PIXEL);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXEL - 1);

    typedef enum logic [1:0] {GNT_NONE, GNT_RD, GNT_WA, GNT_WB} grant_t;

    grant_t grant;
    logic   starveA, starveB;

    logic                  memEn_q, memEn_d;
    logic                  memWe_q, memWe_d;
    logic [ADDR_W-1:0]     memAddr_q, memAddr_d;
    logic [BITS_PIXEL-1:0] memWdata_q, memWdata_d;
    logic                  rdOob_q, rdOob_d;
    logic                  rdValid_q, rdValid_d;
    logic                  rdZero_q, rdZero_d;
    logic                  waFrame_q, waFrame_d;
    logic                  wbErr_q, wbErr_d;
    logic [ADDR_W-1:0]     ptrA_q, ptrA_d;
    logic                  rrA_q, rrA_d;
    logic [CNT_W-1:0]      cntA_q, cntA_d;
    logic [CNT_W-1:0]      cntB_q, cntB_d;
    logic [ADDR_W-1:0]     waAddr;

    // A saturated writer outranks the read port; rrA_q breaks writer ties.
    always_comb begin
        grant   = GNT_NONE;
        starveA = wa_valid && (cntA_q == LIM);
        starveB = wb_valid && (cntB_q == LIM);
        if (!rst_n) begin
            grant = GNT_NONE;
        end else if (starveA && starveB) begin
            grant = rrA_q ? GNT_WA : GNT_WB;
        end else if (starveA) begin
            grant = GNT_WA;
        end else if (starveB) begin
            grant = GNT_WB;
        end else if (rd_valid_i) begin
            grant = GNT_RD;
        end else if (wa_valid && wb_valid) begin
            grant = rrA_q ? GNT_WA : GNT_WB;
        end else if (wa_valid) begin
            grant = GNT_WA;
        end else if (wb_valid) begin
            grant = GNT_WB;
        end
    end

    assign rd_ready = (grant == GNT_RD);
    assign wa_ready = (grant == GNT_WA);
    assign wb_ready = (grant == GNT_WB);

    always_comb begin
        memEn_d    = 1'b0;
        memWe_d    = 1'b0;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        rdOob_d    = 1'b0;
        waFrame_d  = 1'b0;
        wbErr_d    = 1'b0;
        ptrA_d     = ptrA_q;
        rrA_d      = rrA_q;
        waAddr     = wa_sof ? '0 : ptrA_q;

        case (grant)
            GNT_RD: begin
                if ({1'b0, rd_addr} < DEPTH) begin
                    memEn_d   = 1'b1;
                    memAddr_d = rd_addr;
                end else begin
                    rdOob_d = 1'b1;
                end
            end
            GNT_WA: begin
                memEn_d    = 1'b1;
                memWe_d    = 1'b1;
                memAddr_d  = waAddr;
                memWdata_d = wa_pixel;
                rrA_d      = 1'b0;
                if (waAddr == LAST_ADDR) begin
                    ptrA_d    = '0;
                    waFrame_d = 1'b1;
                end else begin
                    ptrA_d = waAddr + ADDR_W'(1);
                end
            end
            GNT_WB: begin
                rrA_d = 1'b1;
                if ({1'b0, wb_addr} < DEPTH) begin
                    memEn_d    = 1'b1;
                    memWe_d    = 1'b1;
                    memAddr_d  = wb_addr;
                    memWdata_d = wb_pixel;
                end else begin
                    wbErr_d = 1'b1;
                end
            end
            default: ;
        endcase

        cntA_d = cntA_q;
        if (!wa_valid || wa_ready) begin
            cntA_d = '0;
        end else if (cntA_q != LIM) begin
            cntA_d = cntA_q + CNT_W'(1);
        end

        cntB_d = cntB_q;
        if (!wb_valid || wb_ready) begin
            cntB_d = '0;
        end else if (cntB_q != LIM) begin
            cntB_d = cntB_q + CNT_W'(1);
        end

        // Out-of-range reads travel one stage behind the RAM path so both kinds keep the same latency.
        rdValid_d = (memEn_q && !memWe_q) || rdOob_q;
        rdZero_d  = rdOob_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            memEn_q    <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            rdOob_q    <= 1'b0;
            rdValid_q  <= 1'b0;
            rdZero_q   <= 1'b0;
            waFrame_q  <= 1'b0;
            wbErr_q    <= 1'b0;
            ptrA_q     <= '0;
            rrA_q      <= 1'b1;
            cntA_q     <= '0;
            cntB_q     <= '0;
        end else begin
            memEn_q    <= memEn_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            rdOob_q    <= rdOob_d;
            rdValid_q  <= rdValid_d;
            rdZero_q   <= rdZero_d;
            waFrame_q  <= waFrame_d;
            wbErr_q    <= wbErr_d;
            ptrA_q     <= ptrA_d;
            rrA_q      <= rrA_d;
            cntA_q     <= cntA_d;
            cntB_q     <= cntB_d;
        end
    end

    assign mem_en     = memEn_q;
    assign mem_we     = memWe_q;
    assign mem_addr   = memAddr_q;
    assign mem_wdata  = memWdata_q;
    assign rd_valid_o = rdValid_q;
    assign rd_data    = (rdValid_q && !rdZero_q) ? mem_rdata : '0;
    assign wa_frame   = waFrame_q;
    assign wb_err     = wbErr_q;

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Directed bench for fb_access_arbiter; the RAM is modelled as data = addr[7:0] ^ 8'h5A.
module tb_fb_access_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_valid_i;
    logic [14:0] rd_addr;
    logic        rd_ready;
    logic        rd_valid_o;
    logic [7:0]  rd_data;
    logic        wa_valid;
    logic [7:0]  wa_pixel;
    logic        wa_sof;
    logic        wa_ready;
    logic        wa_frame;
    logic        wb_valid;
    logic [14:0] wb_addr;
    logic [7:0]  wb_pixel;
    logic        wb_ready;
    logic        wb_err;
    logic        mem_en;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;

    int total = 0;
    int bad   = 0;
    int frameErr;

    fb_access_arbiter #(
        .BITS_PIXEL(8), .NUM_PIXEL(19200), .ADDR_W(15), .STARVE_LIM(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_valid_i(rd_valid_i), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_valid_o(rd_valid_o), .rd_data(rd_data),
        .wa_valid(wa_valid), .wa_pixel(wa_pixel), .wa_sof(wa_sof),
        .wa_ready(wa_ready), .wa_frame(wa_frame),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_pixel(wb_pixel),
        .wb_ready(wb_ready), .wb_err(wb_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= mem_addr[7:0] ^ 8'h5A;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rdV, input logic [14:0] rdA,
                                 input logic waV, input logic [7:0] waP, input logic waS,
                                 input logic wbV, input logic [14:0] wbA, input logic [7:0] wbP);
        rd_valid_i = rdV;
        rd_addr    = rdA;
        wa_valid   = waV;
        wa_pixel   = waP;
        wa_sof     = waS;
        wb_valid   = wbV;
        wb_addr    = wbA;
        wb_pixel   = wbP;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with every requester asserting
        rst_n = 1'b0;
        applyStimulus(1'b1, 15'd3, 1'b1, 8'h01, 1'b0, 1'b1, 15'd4, 8'h02);
        checkOutput("rst_readies", 32'({rd_ready, wa_ready, wb_ready}), 32'h0);
        step();
        checkOutput("rst_mem_en", 32'(mem_en), 32'h0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'h0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'h0);
        checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        checkOutput("rst_rd_out", 32'({rd_valid_o, rd_data}), 32'h0);
        checkOutput("rst_pulses", 32'({wa_frame, wb_err}), 32'h0);
        step();
        rst_n = 1'b1;
        applyStimulus(1'b0, 15'd0, 1'b0, 8'h00, 1'b0, 1'b0, 15'd0, 8'h00);
        step();

        // Read beats writer A
        applyStimulus(1'b1, 15'd5, 1'b1, 8'h11, 1'b1, 1'b0, 15'd0, 8'h00);
        checkOutput("rd_vs_a_ready", 32'({rd_ready, wa_ready, wb_ready}), 32'b100);
        step();
        applyStimulus(1'b0, 15'd0, 1'b0, 8'h00, 1'b0, 1'b0, 15'd0, 8'h00);
        checkOutput("rd_issue", 32'({mem_en, mem_we, mem_addr}), 32'({1'b1, 1'b0, 15'd5}));
        checkOutput("rd_not_yet_valid", 32'(rd_valid_o), 32'h0);
        step();
        checkOutput("rd_valid_2clk", 32'(rd_valid_o), 32'h1);
        checkOutput("rd_data_5", 32'(rd_data), 32'h5F);
        checkOutput("idle_hold_addr", 32'({mem_en, mem_we, mem_addr}), 32'({1'b0, 1'b0, 15'd5}));
        step();
        checkOutput("rd_valid_single", 32'(rd_valid_o), 32'h0);

        // A and B round-robin
        applyStimulus(1'b0, 15'd0, 1'b1, 8'h20, 1'b1, 1'b1, 15'd100, 8'h77);
        checkOutput("rr1_A", 32'({wa_ready, wb_ready}), 32'b10);
        step();
        applyStimulus(1'b0, 15'd0, 1'b1, 8'h21, 1'b0, 1'b1, 15'd100, 8'h77);
        checkOutput("rr1_A_write", 32'({mem_we, mem_addr, mem_wdata}), 32'({1'b1, 15'd0, 8'h20}));
        checkOutput("rr2_B", 32'({wa_ready, wb_ready}), 32'b01);
        step();
        applyStimulus(1'b0, 15'd0, 1'b1, 8'h21, 1'b0, 1'b1, 15'd101, 8'h78);
        checkOutput("rr2_B_write", 32'({mem_we, mem_addr, mem_wdata}), 32'({1'b1, 15'd100, 8'h77}));
        checkOutput("rr3_A", 32'({wa_ready, wb_ready}), 32'b10);
        step();
        applyStimulus(1'b0, 15'd0, 1'b1, 8'h22, 1'b0, 1'b1, 15'd101, 8'h78);
        checkOutput("rr3_A_write", 32'({mem_we, mem_addr, mem_wdata}), 32'({1'b1, 15'd1, 8'h21}));
        checkOutput("rr4_B", 32'({wa_ready, wb_ready}), 32'b01);
        step();
        applyStimulus(1'b0, 15'd0, 1'b0, 8'h00, 1'b0, 1'b0, 15'd0, 8'h00);
        checkOutput("rr4_B_write", 32'({mem_we, mem_addr, mem_wdata}), 32'({1'b1, 15'd101, 8'h78}));
        step();

        // Starvation: A waits 8 cycles behind reads, wins the 9th
        applyStimulus(1'b1, 15'd7, 1'b1, 8'h33, 1'b0, 1'b0, 15'd0, 8'h00);
        for (int k = 1; k <= 8; k++) begin
            checkOutput($sformatf("starve_wait%0d", k), 32'({rd_ready, wa_ready}), 32'b10);
            step();
        end
        checkOutput("starve_win", 32'({rd_ready, wa_ready}), 32'b01);
        step();
        checkOutput("starve_write", 32'({mem_we, mem_addr, mem_wdata}), 32'({1'b1, 15'd2, 8'h33}));
        checkOutput("starve_resume", 32'({rd_ready, wa_ready}), 32'b10);
        step();
        applyStimulus(1'b0, 15'd0, 1'b0, 8'h00, 1'b0, 1'b0, 15'd0, 8'h00);
        step();
        step();
        step();

        // Writer B out of range
        applyStimulus(1'b0, 15'd0, 1'b0, 8'h00, 1'b0, 1'b1, 15'd19200, 8'h55);
        checkOutput("wb_oob_ready", 32'(wb_ready), 32'h1);
        step();
        applyStimulus(1'b0, 15'd0, 1'b0, 8'h00, 1'b0, 1'b0, 15'd0, 8'h00);
        checkOutput("wb_oob_mem", 32'({mem_en, mem_we, mem_addr}), 32'({1'b0, 1'b0, 15'd7}));
        checkOutput("wb_err_pulse", 32'(wb_err), 32'h1);
        step();
        checkOutput("wb_err_clear", 32'(wb_err), 32'h0);

        // Read out of range
        applyStimulus(1'b1, 15'd19300, 1'b0, 8'h00, 1'b0, 1'b0, 15'd0, 8'h00);
        checkOutput("rd_oob_ready", 32'(rd_ready), 32'h1);
        step();
        applyStimulus(1'b0, 15'd0, 1'b0, 8'h00, 1'b0, 1'b0, 15'd0, 8'h00);
        checkOutput("rd_oob_mem", 32'({mem_en, rd_valid_o}), 32'h0);
        step();
        checkOutput("rd_oob_valid", 32'(rd_valid_o), 32'h1);
        checkOutput("rd_oob_data", 32'(rd_data), 32'h0);
        step();
        checkOutput("rd_oob_single", 32'(rd_valid_o), 32'h0);

        // Reset while a read is in flight
        applyStimulus(1'b1, 15'd5, 1'b0, 8'h00, 1'b0, 1'b0, 15'd0, 8'h00);
        checkOutput("flight_rd_ready", 32'(rd_ready), 32'h1);
        step();
        rst_n = 1'b0;
        applyStimulus(1'b0, 15'd0, 1'b1, 8'h44, 1'b0, 1'b0, 15'd0, 8'h00);
        checkOutput("rst_wa_ready", 32'(wa_ready), 32'h0);
        step();
        checkOutput("flight_dropped", 32'({rd_valid_o, mem_en, mem_addr}), 32'h0);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_wa_ready", 32'(wa_ready), 32'h1);
        step();
        checkOutput("post_rst_rd_valid", 32'(rd_valid_o), 32'h0);
        checkOutput("post_rst_write", 32'({mem_we, mem_addr, mem_wdata}), 32'({1'b1, 15'd0, 8'h44}));

        // Full frame from writer A
        frameErr = 0;
        for (int i = 0; i < 19200; i++) begin
            applyStimulus(1'b0, 15'd0, 1'b1, 8'(i), (i == 0), 1'b0, 15'd0, 8'h00);
            step();
            if (!(mem_en === 1'b1 && mem_we === 1'b1 && mem_addr === 15'(i) && mem_wdata === 8'(i)))
                frameErr++;
            if (i < 19199 && wa_frame !== 1'b0)
                frameErr++;
        end
        checkOutput("frame_pixel_errors", 32'(frameErr), 32'h0);
        checkOutput("frame_pulse", 32'(wa_frame), 32'h1);
        applyStimulus(1'b0, 15'd0, 1'b1, 8'hEE, 1'b0, 1'b0, 15'd0, 8'h00);
        step();
        checkOutput("frame_wrap", 32'({mem_we, mem_addr, mem_wdata}), 32'({1'b1, 15'd0, 8'hEE}));
        checkOutput("frame_pulse_end", 32'(wa_frame), 32'h0);
        applyStimulus(1'b0, 15'd0, 1'b0, 8'h00, 1'b0, 1'b0, 15'd0, 8'h00);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
